// File: rtl/qpu_mcu_measure_collect.sv
// qpu_mcu_measure_collect
// Collects per-qubit readout results for one measurement batch and emits a
// single-cycle commit toward the measurement-result registers.
module qpu_mcu_measure_collect #(
    parameter int QUBIT_NUM = 12,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 meas_req_valid,
    output logic                 meas_req_ready,
    input  logic [QUBIT_NUM-1:0] meas_req_list,
    input  logic [TIMEOUT_W-1:0] meas_timeout_cfg,
    input  logic [QUBIT_NUM-1:0] adc_res_vld,
    input  logic [QUBIT_NUM-1:0] adc_res_val,
    output logic                 mcu_measure_o_wen,
    output logic [QUBIT_NUM-1:0] mcu_measure_o_data,
    output logic [QUBIT_NUM-1:0] mcu_measure_o_list,
    output logic                 mcu_measure_o_timeout,
    output logic                 busy,
    output logic                 err_stray
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;

    logic [QUBIT_NUM-1:0]   r_pending;
    logic [QUBIT_NUM-1:0]   r_got;
    logic [QUBIT_NUM-1:0]   r_data;
    logic [TIMEOUT_W-1:0]   r_timer;
    logic [QUBIT_NUM-1:0]   r_outData;
    logic [QUBIT_NUM-1:0]   r_outList;
    logic                   r_outTimeout;
    logic                   r_errStray;

    logic                   w_accept;
    logic [QUBIT_NUM-1:0]   w_acc;
    logic [QUBIT_NUM-1:0]   w_gotNext;
    logic [QUBIT_NUM-1:0]   w_dataNext;
    logic                   w_done;
    logic                   w_timeoutHit;
    logic                   w_enterCommit;
    logic                   w_strayNow;

    // A batch starts only from IDLE with a non-empty list; an empty list is
    // handshaken and silently dropped.
    assign w_accept = (r_state == IDLE) && meas_req_valid && (meas_req_list != '0);

    // First result per qubit wins: only pending qubits not yet seen are taken.
    assign w_acc      = adc_res_vld & r_pending & ~r_got;
    assign w_gotNext  = r_got | w_acc;
    assign w_dataNext = (r_data & ~w_acc) | (adc_res_val & w_acc);
    assign w_done     = (w_gotNext == r_pending);

    // A zero configuration disables the timeout entirely.
    assign w_timeoutHit = (meas_timeout_cfg != '0) &&
                          (r_timer == (meas_timeout_cfg - TIMEOUT_W'(1)));

    assign w_enterCommit = (r_state == COLLECT) && (w_done || w_timeoutHit);

    // While collecting only non-pending strobes are stray; outside a batch
    // every strobe is stray.
    assign w_strayNow = (r_state == COLLECT) ? |(adc_res_vld & ~r_pending)
                                             : |adc_res_vld;

    // State register; reset aborts any batch without a commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and handshake/status outputs, all decoded from the state.
    always_comb begin
        w_stateNext       = r_state;
        meas_req_ready    = 1'b0;
        mcu_measure_o_wen = 1'b0;
        busy              = 1'b1;
        case (r_state)
            IDLE: begin
                meas_req_ready = 1'b1;
                busy           = 1'b0;
                if (w_accept) begin
                    w_stateNext = COLLECT;
                end
            end
            COLLECT: begin
                if (w_done || w_timeoutHit) begin
                    w_stateNext = COMMIT;
                end
            end
            COMMIT: begin
                mcu_measure_o_wen = 1'b1;
                w_stateNext       = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Batch bookkeeping: latch the list on accept, gather results and run
    // the saturating timer while collecting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_got     <= '0;
            r_data    <= '0;
            r_timer   <= '0;
        end else if (w_accept) begin
            r_pending <= meas_req_list;
            r_got     <= '0;
            r_data    <= '0;
            r_timer   <= '0;
        end else if (r_state == COLLECT) begin
            r_got  <= w_gotNext;
            r_data <= w_dataNext;
            if (!w_done && (r_timer != '1)) begin
                r_timer <= r_timer + TIMEOUT_W'(1);
            end
        end
    end

    // Commit payload is captured as COLLECT ends and held until the next commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outData    <= '0;
            r_outList    <= '0;
            r_outTimeout <= 1'b0;
        end else if (w_enterCommit) begin
            r_outData    <= w_dataNext;
            r_outList    <= r_pending;
            r_outTimeout <= !w_done;
        end
    end

    // Sticky stray-result flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_errStray <= 1'b0;
        end else if (w_strayNow) begin
            r_errStray <= 1'b1;
        end
    end

    assign mcu_measure_o_data    = r_outData;
    assign mcu_measure_o_list    = r_outList;
    assign mcu_measure_o_timeout = r_outTimeout;
    assign err_stray             = r_errStray;

endmodule
